// File: rtl/intr_pending_ctrl_if.sv
// Register access bus for the interrupt pending controller.
// master drives strobes/address/write data, slave returns read data.
interface intr_pending_ctrl_if;
  logic        reg_wen;
  logic        reg_ren;
  logic [1:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (
    output reg_wen,
    output reg_ren,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_wen,
    input  reg_ren,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/intr_pending_ctrl.sv
// Slow-domain interrupt pending controller: edge detect, W1C pending,
// sticky overflow, enable mask, registered IRQ + lowest-index ID.
// Ports: sync_clk, sync_resetn (sync, active-low), intr_in[WIDTH],
//   bus (regs 0 PENDING,1 MASK,2 OVERFLOW,3 RAW), irq_out, irq_id,
//   irq_id_vld.
module intr_pending_ctrl #(
  parameter int WIDTH = 1
) (
  input  logic                  sync_clk,
  input  logic                  sync_resetn,
  input  logic [WIDTH-1:0]      intr_in,
  intr_pending_ctrl_if.slave    bus,
  output logic                  irq_out,
  output logic [4:0]            irq_id,
  output logic                  irq_id_vld
);

  logic [WIDTH-1:0] intr_d;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] ovf;
  logic [WIDTH-1:0] mask;
  logic             armed;
  logic [31:0]      rdata;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] oclr;
  logic [WIDTH-1:0] pend_nxt;
  logic [WIDTH-1:0] ovf_nxt;
  logic [WIDTH-1:0] mask_nxt;
  logic [WIDTH-1:0] act;
  logic [4:0]       id_nxt;
  logic [31:0]      rd_sel;

  logic wr_pend;
  logic wr_mask;
  logic wr_ovf;

  assign wr_pend = bus.reg_wen && (bus.reg_addr == 2'd0);
  assign wr_mask = bus.reg_wen && (bus.reg_addr == 2'd1);
  assign wr_ovf  = bus.reg_wen && (bus.reg_addr == 2'd2);

  assign rise = armed ? (intr_in & ~intr_d) : '0;
  assign clr  = wr_pend ? bus.reg_wdata[WIDTH-1:0] : '0;
  assign oclr = wr_ovf ? bus.reg_wdata[WIDTH-1:0] : '0;

  // Set beats clear; an edge on a still-pending bit is an overflow.
  assign pend_nxt = (pending & ~clr) | rise;
  assign ovf_nxt  = (ovf & ~oclr) | (rise & pending);
  assign mask_nxt = wr_mask ? bus.reg_wdata[WIDTH-1:0] : mask;

  // IRQ outputs are registered from next-state values.
  assign act = pend_nxt & mask_nxt;

  always_comb begin
    id_nxt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (act[i]) id_nxt = 5'(i);
    end
  end

  // Reads see pre-write register contents.
  always_comb begin
    rd_sel = '0;
    unique case (bus.reg_addr)
      2'd0: rd_sel = 32'(pending);
      2'd1: rd_sel = 32'(mask);
      2'd2: rd_sel = 32'(ovf);
      2'd3: rd_sel = 32'(intr_d);
    endcase
  end

  always_ff @(posedge sync_clk) begin
    if (!sync_resetn) begin
      intr_d     <= '0;
      pending    <= '0;
      ovf        <= '0;
      mask       <= '0;
      armed      <= 1'b0;
      rdata      <= '0;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      irq_id_vld <= 1'b0;
    end else begin
      intr_d     <= intr_in;
      pending    <= pend_nxt;
      ovf        <= ovf_nxt;
      mask       <= mask_nxt;
      armed      <= 1'b1;
      irq_out    <= |act;
      irq_id     <= id_nxt;
      irq_id_vld <= |act;
      if (bus.reg_ren) rdata <= rd_sel;
    end
  end

  assign bus.reg_rdata = rdata;

endmodule
